// File: rtl/ov7670_pkg.sv
// Shared constants and FSM encoding for the OV7670 frame-buffer write controller.
package ov7670_pkg;

    localparam int H_PIXELS_DEF = 320;
    localparam int V_LINES_DEF  = 240;
    localparam int ADDR_W       = 17;
    localparam int PIX_W        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

endpackage

// File: rtl/ov7670_mem_ctrl_edge_detect.sv
// Single-bit rise/fall pulse generator; pulses are valid in the cycle the new level is seen.
module edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;
    assign fall = ~sig & sig_q;

endmodule

// File: rtl/ov7670_mem_ctrl.sv
// Packs OV7670 RGB565 byte pairs into 16-bit pixels and writes them to a linear frame buffer.
module ov7670_mem_ctrl
    import ov7670_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_en,
    input  logic              vsync,
    input  logic              href,
    input  logic [7:0]        data,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [PIX_W-1:0]  wData,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int PCW = $clog2(H_PIXELS + 1);
    localparam int LCW = $clog2(V_LINES + 1);
    localparam logic [PCW-1:0]    PIX_LIM   = PCW'(H_PIXELS);
    localparam logic [LCW-1:0]    LINE_LIM  = LCW'(V_LINES);
    localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

    state_t            state;
    logic              vsync_rise, vsync_fall;
    logic              href_rise, href_fall;
    logic              phase;
    logic              line_has_byte;
    logic [7:0]        hi_byte_p0;
    logic [PCW-1:0]    pix_cnt;
    logic [LCW-1:0]    line_cnt;
    logic [ADDR_W-1:0] line_base;
    logic              cur_phase;
    logic              in_window;

    edge_detect u_vsync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (vsync),
        .rise    (vsync_rise),
        .fall    (vsync_fall)
    );

    edge_detect u_href_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .sig     (href),
        .rise    (href_rise),
        .fall    (href_fall)
    );

    // A new line always starts on a high byte, even if the previous line was cut short.
    assign cur_phase = phase & ~href_rise;
    assign in_window = (pix_cnt < PIX_LIM) && (line_cnt < LINE_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            we            <= 1'b0;
            wAddr         <= '0;
            wData         <= '0;
            frame_done    <= 1'b0;
            frame_err     <= 1'b0;
            phase         <= 1'b0;
            line_has_byte <= 1'b0;
            hi_byte_p0    <= '0;
            pix_cnt       <= '0;
            line_cnt      <= '0;
            line_base     <= '0;
        end else begin
            we         <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (vsync) state <= SYNC;
                end
                SYNC: begin
                    if (vsync_fall && capture_en) begin
                        state         <= CAPTURE;
                        frame_err     <= 1'b0;
                        phase         <= 1'b0;
                        line_has_byte <= 1'b0;
                        pix_cnt       <= '0;
                        line_cnt      <= '0;
                        line_base     <= '0;
                    end
                end
                CAPTURE: begin
                    if (href) begin
                        line_has_byte <= 1'b1;
                        if (!cur_phase) begin
                            hi_byte_p0 <= data;
                            phase      <= 1'b1;
                        end else begin
                            phase <= 1'b0;
                            if (in_window) begin
                                we      <= 1'b1;
                                wData   <= {hi_byte_p0, data};
                                wAddr   <= line_base + ADDR_W'(pix_cnt);
                                pix_cnt <= pix_cnt + PCW'(1);
                            end else begin
                                frame_err <= 1'b1;
                            end
                        end
                    end else if (href_fall) begin
                        phase         <= 1'b0;
                        pix_cnt       <= '0;
                        line_has_byte <= 1'b0;
                        if (phase) frame_err <= 1'b1;
                        // Saturating the line count keeps line_base inside the buffer.
                        if (line_has_byte && (line_cnt < LINE_LIM)) begin
                            line_cnt  <= line_cnt + LCW'(1);
                            line_base <= line_base + LINE_STEP;
                        end
                    end
                    // A pixel completing on this edge still writes; frame_done lands with it.
                    if (vsync_rise) begin
                        state         <= SYNC;
                        frame_done    <= 1'b1;
                        phase         <= 1'b0;
                        line_has_byte <= 1'b0;
                        pix_cnt       <= '0;
                        line_cnt      <= '0;
                        line_base     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
